// File: rtl/rr_reg_arbiter_pkg.sv
// Shared definitions for the round-robin register arbiter: state encoding
// and a constant-evaluable ceil(log2) used to size index and counter fields.
package rr_reg_arbiter_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_reg_arbiter_pick.sv
// Round-robin picker: first requester after `owner` (wrapping), with owner
// itself considered last so it only re-wins when nobody else is asking.
module rr_pick
  import rr_reg_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int OW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [OW-1:0]    owner,
  output logic [OW-1:0]    pick,
  output logic             any_req
);

  logic [OW-1:0] idx_s;

  // Scan farthest-to-nearest so the nearest requester after owner is kept last.
  always_comb begin
    pick    = owner;
    any_req = 1'b0;
    idx_s   = owner;
    for (int k = N_REQ; k >= 1; k--) begin
      idx_s   = OW'((int'(owner) + k) % N_REQ);
      pick    = req[idx_s] ? idx_s : pick;
      any_req = any_req | req[idx_s];
    end
  end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter granting one requester at a time write access to a
// shared WIDTH-bit register, with ownership bounded to MAX_HOLD writes.
module rr_reg_arbiter
  import rr_reg_arbiter_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   wr_data,
  output logic [N_REQ-1:0]         gnt,
  output logic [clog2(N_REQ)-1:0]  owner,
  output logic [WIDTH-1:0]         q,
  output logic                     q_valid
);

  localparam int OW = clog2(N_REQ);
  localparam int HW = clog2(MAX_HOLD + 1);

  logic [0:0]       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_valid_q, q_valid_d;

  logic [OW-1:0]    pick_s;
  logic             any_req_s;
  logic             w_s;
  logic             release_s;

  rr_pick #(
    .N_REQ (N_REQ),
    .OW    (OW)
  ) u_pick (
    .req     (req),
    .owner   (owner_q),
    .pick    (pick_s),
    .any_req (any_req_s)
  );

  // Next-state: grant selection, hold counting and owner writes to q.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    hold_d    = hold_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    w_s       = req[owner_q];
    // The owner's final permitted write and its release happen on the same edge.
    release_s = !w_s || (hold_q == HW'(MAX_HOLD - 1));
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          state_d = ST_BUSY;
          gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << pick_s;
          owner_d = pick_s;
          hold_d  = {HW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (w_s) begin
          q_d       = wr_data[int'(owner_q)*WIDTH +: WIDTH];
          q_valid_d = 1'b1;
          hold_d    = hold_q + HW'(1);
        end else begin
          q_d = q_q;
        end
        if (release_s && any_req_s) begin
          gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << pick_s;
          owner_d = pick_s;
          hold_d  = {HW{1'b0}};
        end else if (release_s) begin
          state_d = ST_IDLE;
          gnt_d   = {N_REQ{1'b0}};
          hold_d  = {HW{1'b0}};
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = {N_REQ{1'b0}};
        hold_d  = {HW{1'b0}};
      end
    endcase
  end

  // Arbiter state and shared register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= {N_REQ{1'b0}};
      owner_q   <= OW'(N_REQ - 1);
      hold_q    <= {HW{1'b0}};
      q_q       <= {WIDTH{1'b0}};
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      hold_q    <= hold_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign q       = q_q;
  assign q_valid = q_valid_q;

endmodule
